// File: rtl/spi_reg_tx_if.sv
// spi_reg_tx_if
//   Bundles the command handshake and SPI pins of spi_reg_tx.
//   master : command source (drives i_valid/i_cmd/i_data, observes the rest)
//   slave  : spi_reg_tx itself
//   Signals:
//     i_valid  command offered           o_ready  command can be accepted
//     i_cmd    4-bit register command    i_data   12-bit payload
//     o_sclk   SPI clock, idle low       o_ss_n   active-low slave select
//     o_mosi   serial data, MSB first    o_busy   frame in flight or queued
//     o_done   one-cycle pulse per completed frame
interface spi_reg_tx_if;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_cmd;
  logic [11:0] i_data;
  logic        o_sclk;
  logic        o_ss_n;
  logic        o_mosi;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_valid, i_cmd, i_data,
    input  o_ready, o_sclk, o_ss_n, o_mosi, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_cmd, i_data,
    output o_ready, o_sclk, o_ss_n, o_mosi, o_busy, o_done
  );
endinterface

// File: rtl/spi_reg_tx.sv
// spi_reg_tx
//   Serialises a register command (4-bit code + 1/6/12-bit payload) onto an
//   SPI link, mode 0 (SCLK idle low, MOSI changes while SCLK low).
//   Frame: SETUP, then per bit HIGH (and LOW between bits), then HOLD with
//   select still asserted, then GAP with select released for SS_GAP cycles.
//
//   Parameters:
//     CLK_DIV : clk cycles per SCLK half-period (2..255)
//     SS_GAP  : minimum clk cycles o_ss_n stays high between frames (1..255)
//
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high; aborts any frame and drops any queued command
//     bus   : spi_reg_tx_if.slave (handshake + SPI pins, see interface header)
//
//   Build option:
//     SPI_REG_TX_QUEUE_EN : adds a one-entry holding register so a command can
//     be accepted while a frame is in flight; it launches straight from GAP
//     into SETUP. Without it, commands are accepted only in IDLE.
module spi_reg_tx #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 2
) (
  input  logic         clk,
  input  logic         reset,
  spi_reg_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(SS_GAP - 1);

  // Frame left-aligned in 16 bits: cmd first, then the low LEN payload bits.
  function automatic logic [15:0] build_frame(input logic [3:0] cmd,
                                              input logic [11:0] data);
    logic [15:0] f;
    if (cmd == 4'd3)
      f = {cmd, data};
    else if (cmd == 4'd0 || cmd == 4'd1 || cmd == 4'd2 || cmd == 4'd4)
      f = {cmd, data[5:0], 6'b0};
    else
      f = {cmd, data[0], 11'b0};
    return f;
  endfunction

  // Number of bits after the first one, i.e. frame length minus one.
  function automatic logic [3:0] bits_after_first(input logic [3:0] cmd);
    logic [3:0] n;
    if (cmd == 4'd3)
      n = 4'd15;
    else if (cmd == 4'd0 || cmd == 4'd1 || cmd == 4'd2 || cmd == 4'd4)
      n = 4'd9;
    else
      n = 4'd4;
    return n;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bits_q, bits_d;
  logic [15:0] sh_q, sh_d;
  logic        sclk_q, sclk_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;

  logic        ready;
  logic        accept;
  logic        launch;
  logic [3:0]  launch_cmd;
  logic [11:0] launch_data;
  logic [15:0] launch_frame;

`ifdef SPI_REG_TX_QUEUE_EN
  logic        hold_vld_q, hold_vld_d;
  logic [3:0]  hold_cmd_q, hold_cmd_d;
  logic [11:0] hold_data_q, hold_data_d;
  logic        take_input;

  assign ready       = !hold_vld_q;
  assign bus.o_busy  = (state_q != IDLE) || hold_vld_q;
`else
  assign ready       = (state_q == IDLE);
  assign bus.o_busy  = (state_q != IDLE);
`endif

  assign accept       = bus.i_valid && ready;
  assign bus.o_ready  = ready;
  assign bus.o_sclk   = sclk_q;
  assign bus.o_ss_n   = ss_n_q;
  assign bus.o_mosi   = mosi_q;
  assign bus.o_done   = done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    bits_d      = bits_q;
    sh_d        = sh_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    launch      = 1'b0;
    launch_cmd  = bus.i_cmd;
    launch_data = bus.i_data;
`ifdef SPI_REG_TX_QUEUE_EN
    hold_vld_d  = hold_vld_q;
    hold_cmd_d  = hold_cmd_q;
    hold_data_d = hold_data_q;
    take_input  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
`ifdef SPI_REG_TX_QUEUE_EN
        if (hold_vld_q) begin
          launch      = 1'b1;
          launch_cmd  = hold_cmd_q;
          launch_data = hold_data_q;
          hold_vld_d  = 1'b0;
        end else if (accept) begin
          launch     = 1'b1;
          take_input = 1'b1;
        end
`else
        if (accept) launch = 1'b1;
`endif
      end

      SETUP, LOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = HIGH;
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
        end
      end

      HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = 8'd0;
          sclk_d = 1'b0;
          if (bits_q == 4'd0) begin
            state_d = HOLD;
          end else begin
            // Next bit goes out together with the falling SCLK edge.
            state_d = LOW;
            bits_d  = bits_q - 4'd1;
            sh_d    = {sh_q[14:0], 1'b0};
            mosi_d  = sh_q[14];
          end
        end
      end

      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = GAP;
          cnt_d   = 8'd0;
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
`ifdef SPI_REG_TX_QUEUE_EN
          // A pending command skips IDLE so select stays high only SS_GAP cycles.
          if (hold_vld_q) begin
            launch      = 1'b1;
            launch_cmd  = hold_cmd_q;
            launch_data = hold_data_q;
            hold_vld_d  = 1'b0;
          end else if (accept) begin
            launch     = 1'b1;
            take_input = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        sclk_d  = 1'b0;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase

    launch_frame = build_frame(launch_cmd, launch_data);

    if (launch) begin
      state_d = SETUP;
      cnt_d   = 8'd0;
      ss_n_d  = 1'b0;
      sclk_d  = 1'b0;
      sh_d    = launch_frame;
      mosi_d  = launch_frame[15];
      bits_d  = bits_after_first(launch_cmd);
    end

`ifdef SPI_REG_TX_QUEUE_EN
    // Anything accepted but not launched this cycle waits in the holding register.
    if (accept && !take_input) begin
      hold_vld_d  = 1'b1;
      hold_cmd_d  = bus.i_cmd;
      hold_data_d = bus.i_data;
    end
`endif
  end

  // Control and SPI output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bits_q  <= 4'd0;
      sclk_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  // Data registers: contents are don't-care until a launch loads them
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

`ifdef SPI_REG_TX_QUEUE_EN
  always_ff @(posedge clk) begin
    if (reset) hold_vld_q <= 1'b0;
    else       hold_vld_q <= hold_vld_d;
  end

  always_ff @(posedge clk) begin
    hold_cmd_q  <= hold_cmd_d;
    hold_data_q <= hold_data_d;
  end
`endif

endmodule

// File: doc/spi_reg_tx.md
SPI_REG_TX -- requirements
Module: spi_reg_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 2..255).
REQ-002 SHALL provide parameter SS_GAP, default 2, meaning minimum clk cycles o_ss_n stays high between frames (legal range 1..255).
REQ-003 SHALL provide port clk, input, 1, system clock; all logic is on its rising edge.
REQ-004 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port i_valid, input, 1, command offered.
REQ-006 SHALL provide port o_ready, output, 1, command can be accepted this cycle.
REQ-007 SHALL provide port i_cmd, input, 4, register command code.
REQ-008 SHALL provide port i_data, input, 12, payload; only the low LEN bits are used.
REQ-009 SHALL provide port o_sclk, output, 1, SPI clock, idle low.
REQ-010 SHALL provide port o_ss_n, output, 1, active-low slave select.
REQ-011 SHALL provide port o_mosi, output, 1, serial data, MSB first.
REQ-012 SHALL provide port o_busy, output, 1, high while a frame is in flight or queued.
REQ-013 SHALL provide port o_done, output, 1, one-cycle pulse per completed frame.

Function
REQ-014 SHALL accept a command on any cycle where i_valid && o_ready, capturing i_cmd and i_data.
REQ-015 SHALL set payload length LEN from the captured command: 0,1,2,4 -> 6 bits; 3 -> 12 bits; 5 -> 1 bit; 6..15 -> 1 bit.
REQ-016 SHALL transmit a frame of 4+LEN bits: i_cmd[3:0] MSB first, then i_data[LEN-1:0] MSB first.
REQ-017 SHALL implement the FSM states IDLE, SETUP, HIGH, LOW, HOLD and GAP.
REQ-018 SHALL, on acceptance in IDLE, enter SETUP on the next cycle, driving o_ss_n=0, o_sclk=0 and o_mosi=bit 0.
REQ-019 SHALL hold SETUP and each LOW state for CLK_DIV cycles with o_sclk=0, then enter HIGH.
REQ-020 SHALL hold HIGH for CLK_DIV cycles with o_sclk=1 and o_mosi stable, then enter LOW with o_mosi=next bit, or enter HOLD after the last bit.
REQ-021 SHALL change o_mosi only on entry to SETUP or LOW, so it is never changed while o_sclk=1.
REQ-022 SHALL hold HOLD for CLK_DIV cycles with o_sclk=0 and o_ss_n=0, then enter GAP.
REQ-023 SHALL drive o_ss_n=1, o_sclk=0 and o_mosi=0 in GAP and pulse o_done on the first GAP cycle.
REQ-024 SHALL hold GAP for SS_GAP cycles, then enter IDLE (or SETUP per REQ-030).
REQ-025 SHALL, for a frame of N=4+LEN bits, keep o_ss_n low for exactly (2N+1)*CLK_DIV cycles containing exactly N o_sclk rising edges.
REQ-026 SHALL register all SPI outputs, so they are glitch-free.
REQ-027 SHALL drive o_busy = (state != IDLE) || queue occupied.
REQ-028 SHALL treat commands 6..15 as legal; they are sent per REQ-015 and produce no error.

Reset
REQ-029 SHALL, on reset (including mid-frame), on the next cycle set state=IDLE, o_ss_n=1, o_sclk=0, o_mosi=0, o_done=0, o_busy=0 and o_ready=1, and discard any in-flight or queued command.

Configuration
REQ-030 SHALL, with SPI_REG_TX_QUEUE_EN defined, include a one-entry holding register, with o_ready = holding register empty.
- A command accepted while a frame is busy is stored.
- After the current GAP completes, the stored command enters SETUP directly, with no IDLE cycle.
- A command accepted in IDLE with the holding register empty starts immediately, per REQ-018.
REQ-031 SHALL, without SPI_REG_TX_QUEUE_EN, have no holding register, with o_ready = (state==IDLE).

Verification
REQ-032 SHALL cover: CLK_DIV=4, cmd=0, data=12'h015 -> bit sequence 0000_010101, o_ss_n low 84 cycles, 10 rising edges, one o_done.
REQ-033 SHALL cover: cmd=3, data=12'hA5C -> 16 bits 0011_101001011100, o_ss_n low 132 cycles.
REQ-034 SHALL cover: cmd=5, data=12'hFFF -> 5 bits 0101_1, o_ss_n low 44 cycles.
REQ-035 SHALL cover: reset asserted at 6th o_sclk rise of a cmd=1 frame -> next cycle o_ss_n=1, o_sclk=0, no o_done, o_ready=1.
REQ-036 SHALL cover: back-to-back cmd=0 then cmd=2 with i_valid held -> o_ss_n high exactly SS_GAP cycles with the macro defined, SS_GAP+1 without.
REQ-037 SHALL cover: loopback into the register receiver with cmds 0..5 -> receiver latches sky, floor, leak, other, vshift and vinf equal to the sent data after load_new.
